// File: rtl/namuru_mc_if.sv
// WISHBONE bus bundle for the namuru_mc correlator block.
// The slave side is the correlator; the master side is the host CPU.
interface namuru_mc_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/namuru_mc.sv
// Multi-channel GPS correlator: NCO carrier wipe-off, I/Q integrate-and-dump,
// WISHBONE register access.
module namuru_mc #(
    parameter int NCH   = 4,
    parameter int ACC_W = 24,
    parameter int TIC_W = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    namuru_mc_if.slave  wb,
    input  logic        gps_rec_sign,
    input  logic        gps_rec_mag,
    output logic        accum_interrupt,
    output logic        gps_led
);

    logic [1:0]             r_sign_sync;
    logic [1:0]             r_mag_sync;
    logic                   r_ack;
    logic                   r_en;
    logic                   r_mask;
    logic                   r_rdy;
    logic                   r_ovr;
    logic                   r_led;
    logic [TIC_W-1:0]       r_tic;
    logic [TIC_W-1:0]       r_cnt;
    logic [31:0]            r_freq   [NCH];
    logic [31:0]            r_phase  [NCH];
    logic signed [ACC_W-1:0] r_acc_i [NCH];
    logic signed [ACC_W-1:0] r_acc_q [NCH];
    logic signed [ACC_W-1:0] r_dump_i [NCH];
    logic signed [ACC_W-1:0] r_dump_q [NCH];
    logic signed [ACC_W-1:0] w_sum_i [NCH];
    logic signed [ACC_W-1:0] w_sum_q [NCH];

    logic [7:0]        w_a;
    logic              w_req;
    logic              w_wr;
    logic              w_rd_stat;
    logic              w_dump;
    logic signed [2:0] w_mag;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_a       = wb.wb_adr_i[9:2];
    assign w_req     = wb.wb_stb_i & wb.wb_cyc_i;
    assign w_wr      = r_ack & w_req & wb.wb_we_i;
    assign w_rd_stat = r_ack & w_req & ~wb.wb_we_i & (w_a == 8'h02);
    assign w_dump    = r_en & (r_cnt == '0);
    assign w_mag     = r_mag_sync[1] ? 3'sd3 : 3'sd1;
    assign w_unused  = ^{wb.wb_adr_i[31:10], wb.wb_adr_i[1:0]};

    function automatic logic [31:0] merge(
        input logic [31:0] o,
        input logic [31:0] n,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic signed [2:0] prod(
        input logic        neg,
        input logic        sgn,
        input logic signed [2:0] m
    );
        return (neg ^ sgn) ? -m : m;
    endfunction

    // Wide add, then clamp if the sign of the result escaped ACC_W bits.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [2:0]       p
    );
        logic signed [ACC_W:0] t;
        t = (ACC_W+1)'(a) + (ACC_W+1)'(p);
        if (t[ACC_W] != t[ACC_W-1])
            return t[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        return t[ACC_W-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_sum_i[c] = sat_add(r_acc_i[c],
                prod(r_phase[c][31], r_sign_sync[1], w_mag));
            w_sum_q[c] = sat_add(r_acc_q[c],
                prod(r_phase[c][31] ^ r_phase[c][30], r_sign_sync[1], w_mag));
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sign_sync <= '0;
            r_mag_sync  <= '0;
            r_ack       <= 1'b0;
            r_en        <= 1'b0;
            r_mask      <= 1'b0;
            r_rdy       <= 1'b0;
            r_ovr       <= 1'b0;
            r_led       <= 1'b0;
            r_tic       <= '0;
            r_cnt       <= '0;
        end else begin
            r_sign_sync <= {r_sign_sync[0], gps_rec_sign};
            r_mag_sync  <= {r_mag_sync[0], gps_rec_mag};
            r_ack       <= w_req & ~r_ack;
            if (w_wr) begin
                if (w_a == 8'h00 && wb.wb_sel_i[0])
                    r_en <= wb.wb_dat_i[0];
                if (w_a == 8'h01)
                    r_tic <= TIC_W'(merge(32'(r_tic), wb.wb_dat_i, wb.wb_sel_i));
                if (w_a == 8'h03 && wb.wb_sel_i[0])
                    r_mask <= wb.wb_dat_i[0];
            end
            // Counter tracks TIC_PERIOD while idle so enable starts a full period.
            if (!r_en || w_dump)
                r_cnt <= r_tic;
            else
                r_cnt <= r_cnt - TIC_W'(1);
            if (w_rd_stat) begin
                r_rdy <= w_dump;
                r_ovr <= w_dump & r_rdy;
            end else begin
                r_rdy <= r_rdy | w_dump;
                r_ovr <= r_ovr | (w_dump & r_rdy);
            end
            if (w_dump)
                r_led <= ~r_led;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_freq[c]   <= '0;
                r_phase[c]  <= '0;
                r_acc_i[c]  <= '0;
                r_acc_q[c]  <= '0;
                r_dump_i[c] <= '0;
                r_dump_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_wr && w_a == 8'(16 + 4*c))
                    r_freq[c] <= merge(r_freq[c], wb.wb_dat_i, wb.wb_sel_i);
                if (!r_en) begin
                    r_phase[c] <= '0;
                    r_acc_i[c] <= '0;
                    r_acc_q[c] <= '0;
                end else begin
                    r_phase[c] <= r_phase[c] + r_freq[c];
                    if (w_dump) begin
                        r_dump_i[c] <= w_sum_i[c];
                        r_dump_q[c] <= w_sum_q[c];
                        r_acc_i[c]  <= '0;
                        r_acc_q[c]  <= '0;
                    end else begin
                        r_acc_i[c] <= w_sum_i[c];
                        r_acc_q[c] <= w_sum_q[c];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_ack) begin
            unique case (1'b1)
                (w_a == 8'h00): w_rdata = {31'd0, r_en};
                (w_a == 8'h01): w_rdata = 32'(r_tic);
                (w_a == 8'h02): w_rdata = {30'd0, r_ovr, r_rdy};
                (w_a == 8'h03): w_rdata = {31'd0, r_mask};
                default: begin
                    for (int c = 0; c < NCH; c++) begin
                        if (w_a[7:2] == 6'(4 + c)) begin
                            case (w_a[1:0])
                                2'd0:    w_rdata = r_freq[c];
                                2'd1:    w_rdata = 32'(r_dump_i[c]);
                                2'd2:    w_rdata = 32'(r_dump_q[c]);
                                default: w_rdata = '0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign wb.wb_ack_o     = r_ack;
    assign wb.wb_dat_o     = w_rdata;
    assign accum_interrupt = r_rdy & r_mask;
    assign gps_led         = r_led;

endmodule
